// File: rtl/spgd_seq_pkg.sv
// Shared types and helpers for the SPGD pulse sequencer: state encoding, width helpers, saturating add.
// Optional alternate-sign perturbation order is selected with the SPGD_SEQ_ALT_SIGN_EN macro in the top.
package spgd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE_P = 3'd1,
        ST_MEAS_P   = 3'd2,
        ST_SETTLE_M = 3'd3,
        ST_MEAS_M   = 3'd4,
        ST_UPDATE   = 3'd5
    } state_e;

    localparam int unsigned DEF_DAC_WIDTH = 14;
    localparam int unsigned DEF_ADC_WIDTH = 14;

    function automatic int unsigned acc_width(input int unsigned adc_w, input int unsigned meas_log2);
        return adc_w + meas_log2;
    endfunction

    function automatic int unsigned grad_width(input int unsigned adc_w, input int unsigned meas_log2);
        return adc_w + meas_log2 + 1;
    endfunction

    // Adds two wide signed values and clamps to the range of a w-bit signed code.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/spgd_window_acc.sv
// Signed window accumulator: synchronous clear, enable-gated accumulation of sign-extended samples.
module spgd_window_acc
    import spgd_seq_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_ADC_WIDTH,
    parameter int unsigned ACC_W = DEF_ADC_WIDTH + 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(signed'(din));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/spgd_pulse_sequencer.sv
// One SPGD perturbation cycle per accepted trigger edge: +delta / -delta windows, then base update.
// Define SPGD_SEQ_ALT_SIGN_EN to alternate the perturbation order on every accepted trigger.
module spgd_pulse_sequencer
    import spgd_seq_pkg::*;
#(
    parameter int unsigned DAC_WIDTH     = DEF_DAC_WIDTH,
    parameter int unsigned ADC_WIDTH     = DEF_ADC_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned MEAS_LOG2     = 6,
    parameter int unsigned GAIN_SHIFT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s,
    input  logic                                 enable,
    input  logic [ADC_WIDTH-1:0]                 adc_in,
    input  logic [DAC_WIDTH-2:0]                 delta,
    output logic [DAC_WIDTH-1:0]                 dac_out,
    output logic [2:0]                           phase,
    output logic                                 busy,
    output logic                                 done,
    output logic [ADC_WIDTH+MEAS_LOG2:0]         grad
);

    localparam int unsigned ACC_W    = acc_width(ADC_WIDTH, MEAS_LOG2);
    localparam int unsigned GRAD_W   = grad_width(ADC_WIDTH, MEAS_LOG2);
    localparam int unsigned MEAS_LEN = 1 << MEAS_LOG2;
    localparam int unsigned MAX_LEN  = (SETTLE_CYCLES > MEAS_LEN) ? SETTLE_CYCLES : MEAS_LEN;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);

    logic                     s_q1, s_q2, edge_q;
    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DAC_WIDTH-2:0]     delta_q, delta_d;
    logic [DAC_WIDTH-1:0]     base_q, base_d;
    logic [DAC_WIDTH-1:0]     dac_q, dac_d;
    logic                     done_q, done_d;
    logic [GRAD_W-1:0]        grad_q, grad_d;

    logic                     clr_p, en_p, clr_m, en_m;
    logic [ACC_W-1:0]         acc_p, acc_m;
    logic signed [GRAD_W-1:0] diff, step;
    logic signed [63:0]       dext_d, dext_q;
    logic                     neg_first_d, neg_first_q;
    logic                     settle_last, meas_last;

`ifdef SPGD_SEQ_ALT_SIGN_EN
    logic tog_q, tog_d;
    logic sign_q, sign_d;
`endif

    spgd_window_acc #(.IN_W(ADC_WIDTH), .ACC_W(ACC_W)) u_acc_p (
        .clk(clk), .rst(rst), .clr(clr_p), .en(en_p), .din(adc_in), .acc(acc_p)
    );

    spgd_window_acc #(.IN_W(ADC_WIDTH), .ACC_W(ACC_W)) u_acc_m (
        .clk(clk), .rst(rst), .clr(clr_m), .en(en_m), .din(adc_in), .acc(acc_m)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        delta_d     = delta_q;
        base_d      = base_q;
        grad_d      = grad_q;
        done_d      = (state_q == ST_UPDATE);
        clr_p       = 1'b0;
        en_p        = 1'b0;
        clr_m       = 1'b0;
        en_m        = 1'b0;
        settle_last = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));
        meas_last   = (cnt_q == CNT_W'(MEAS_LEN - 1));
`ifdef SPGD_SEQ_ALT_SIGN_EN
        tog_d       = tog_q;
        sign_d      = sign_q;
`endif

        // The "P" window always measures the first perturbation; the sign flop says which one that was.
        diff = GRAD_W'(signed'(acc_p)) - GRAD_W'(signed'(acc_m));
`ifdef SPGD_SEQ_ALT_SIGN_EN
        if (sign_q) begin
            diff = -diff;
        end
`endif
        step = diff >>> (MEAS_LOG2 + GAIN_SHIFT);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (edge_q && enable) begin
                    state_d = ST_SETTLE_P;
                    delta_d = delta;
`ifdef SPGD_SEQ_ALT_SIGN_EN
                    sign_d  = tog_q;
                    tog_d   = ~tog_q;
`endif
                end
            end
            ST_SETTLE_P: begin
                if (settle_last) begin
                    state_d = ST_MEAS_P;
                    cnt_d   = '0;
                    clr_p   = 1'b1;
                end
            end
            ST_MEAS_P: begin
                en_p = 1'b1;
                if (meas_last) begin
                    state_d = ST_SETTLE_M;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE_M: begin
                if (settle_last) begin
                    state_d = ST_MEAS_M;
                    cnt_d   = '0;
                    clr_m   = 1'b1;
                end
            end
            ST_MEAS_M: begin
                en_m = 1'b1;
                if (meas_last) begin
                    state_d = ST_UPDATE;
                    cnt_d   = '0;
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grad_d  = diff;
                base_d  = DAC_WIDTH'(sat_add(64'(signed'(base_q)), 64'(step), DAC_WIDTH));
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef SPGD_SEQ_ALT_SIGN_EN
        neg_first_d = sign_d;
        neg_first_q = sign_q;
`else
        neg_first_d = 1'b0;
        neg_first_q = 1'b0;
`endif
        dext_d = signed'(64'(delta_d));
        dext_q = signed'(64'(delta_q));

        // The DAC register follows the state being entered so the code changes with the state.
        dac_d = dac_q;
        case (state_d)
            ST_IDLE:     dac_d = base_d;
            ST_SETTLE_P: dac_d = DAC_WIDTH'(sat_add(64'(signed'(base_q)),
                                                    neg_first_d ? -dext_d : dext_d, DAC_WIDTH));
            ST_SETTLE_M: dac_d = DAC_WIDTH'(sat_add(64'(signed'(base_q)),
                                                    neg_first_q ? dext_q : -dext_q, DAC_WIDTH));
            default:     dac_d = dac_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q1    <= 1'b0;
            s_q2    <= 1'b0;
            edge_q  <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            delta_q <= '0;
            base_q  <= '0;
            dac_q   <= '0;
            done_q  <= 1'b0;
            grad_q  <= '0;
`ifdef SPGD_SEQ_ALT_SIGN_EN
            tog_q   <= 1'b0;
            sign_q  <= 1'b0;
`endif
        end else begin
            s_q1    <= s;
            s_q2    <= s_q1;
            edge_q  <= s_q1 & ~s_q2;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            delta_q <= delta_d;
            base_q  <= base_d;
            dac_q   <= dac_d;
            done_q  <= done_d;
            grad_q  <= grad_d;
`ifdef SPGD_SEQ_ALT_SIGN_EN
            tog_q   <= tog_d;
            sign_q  <= sign_d;
`endif
        end
    end

    assign dac_out = dac_q;
    assign phase   = state_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign grad    = grad_q;

endmodule
